// File: rtl/mux2_1.sv
// mux2_1: width-parameterised 2:1 selector built three ways (gate primitives,
// dataflow, behavioural), with a registered output taken from the behavioural
// path and an optional sticky equivalence checker across the three styles.
// Optional feature macro: MUX2_1_CROSSCHECK_EN (defined -> checker built,
// undefined -> MISMATCH tied low).
module mux2_1 #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SEL,
  input  logic             EN,
  output logic [WIDTH-1:0] OUT_GATES,
  output logic [WIDTH-1:0] OUT_DATAFLOW,
  output logic [WIDTH-1:0] OUT_BEHAVIORAL,
  output logic [WIDTH-1:0] OUT_Q,
  output logic             MISMATCH
);

  wire  [WIDTH-1:0] gates_s;
  logic [WIDTH-1:0] dataflow_s;
  logic [WIDTH-1:0] behavioral_s;
  logic [WIDTH-1:0] q_r;

  // Gate-level path: every bit has its own inverter so no logic is shared
  // with the other two styles or between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire sel_n_s;
    wire a_term_s;
    wire b_term_s;
    not u_not   (sel_n_s,    SEL);
    and u_and_a (a_term_s,   A[i], sel_n_s);
    and u_and_b (b_term_s,   B[i], SEL);
    or  u_or    (gates_s[i], a_term_s, b_term_s);
  end

  // Dataflow path: a single conditional assignment.
  assign dataflow_s = SEL ? B : A;

  // Behavioural path: fully assigned on every branch so nothing latches.
  always_comb begin
    behavioral_s = A;
    if (SEL) begin
      behavioral_s = B;
    end else begin
      behavioral_s = A;
    end
  end

  // Output register: loads the behavioural result when enabled, else holds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_r <= '0;
    end else if (EN) begin
      q_r <= behavioral_s;
    end else begin
      q_r <= q_r;
    end
  end

`ifdef MUX2_1_CROSSCHECK_EN
  logic mismatch_r;

  // Sticky checker: any disagreement (including X/Z) between the three styles
  // sets the flag until the next reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mismatch_r <= 1'b0;
    end else if ((gates_s !== dataflow_s) || (dataflow_s !== behavioral_s) ||
                 (gates_s !== behavioral_s)) begin
      mismatch_r <= 1'b1;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign MISMATCH = mismatch_r;
`else
  assign MISMATCH = 1'b0;
`endif

  assign OUT_GATES      = gates_s;
  assign OUT_DATAFLOW   = dataflow_s;
  assign OUT_BEHAVIORAL = behavioral_s;
  assign OUT_Q          = q_r;

endmodule

// File: tb/tb_mux2_1.sv
// Directed bench for mux2_1: one 8-bit and one 1-bit instance.
module tb_mux2_1;

`ifdef MUX2_1_CROSSCHECK_EN
  localparam logic XCHK = 1'b1;
`else
  localparam logic XCHK = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       SEL;
  logic       EN;
  logic [7:0] a8, b8;
  logic [7:0] g8, d8, h8, q8;
  logic       mm8;
  logic       a1, b1;
  logic       g1, d1, h1, q1;
  logic       mm1;

  int tests;
  int fails;

  mux2_1 #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .A(a8), .B(b8), .SEL(SEL), .EN(EN),
    .OUT_GATES(g8), .OUT_DATAFLOW(d8), .OUT_BEHAVIORAL(h8),
    .OUT_Q(q8), .MISMATCH(mm8)
  );

  mux2_1 #(.WIDTH(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .A(a1), .B(b1), .SEL(SEL), .EN(EN),
    .OUT_GATES(g1), .OUT_DATAFLOW(d1), .OUT_BEHAVIORAL(h1),
    .OUT_Q(q1), .MISMATCH(mm1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic       en;
    logic [7:0] exp_comb;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_comb8(input string name, input logic [7:0] exp);
    check({name, "_gates"}, {56'd0, g8}, {56'd0, exp});
    check({name, "_dataflow"}, {56'd0, d8}, {56'd0, exp});
    check({name, "_behav"}, {56'd0, h8}, {56'd0, exp});
  endtask

  task automatic check_comb1(input string name, input logic exp);
    check({name, "_gates"}, {63'd0, g1}, {63'd0, exp});
    check({name, "_dataflow"}, {63'd0, d1}, {63'd0, exp});
    check({name, "_behav"}, {63'd0, h1}, {63'd0, exp});
  endtask

  initial begin
    logic exp1;
    tests = 0;
    fails = 0;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h3C};
    vecs[2] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'hA5};
    vecs[3] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 8'h3C, 8'hA5};
    vecs[4] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'hA5};
    vecs[5] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h3C};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00};
    vecs[8] = '{8'h0F, 8'hF0, 1'b0, 1'b1, 8'h0F, 8'h0F};
    vecs[9] = '{8'h0F, 8'hF0, 1'b1, 1'b1, 8'hF0, 8'hF0};

    // Reset state with all-zero inputs.
    RST_N = 1'b0;
    SEL   = 1'b0;
    EN    = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
    #2;
    check("rst_q8", {56'd0, q8}, 64'd0);
    check("rst_mm8", {63'd0, mm8}, 64'd0);
    check("rst_q1", {63'd0, q1}, 64'd0);
    check("rst_mm1", {63'd0, mm1}, 64'd0);
    check_comb8("rst_comb8", 8'h00);
    check_comb1("rst_comb1", 1'b0);

    @(negedge CLK);
    RST_N = 1'b1;

    // 1-bit sequence, 10 ns apart.
    a1 = 1'b1; b1 = 1'b1; SEL = 1'b0;
    #1; check_comb1("seq1_a", 1'b1);
    #9; a1 = 1'b0; SEL = 1'b1;
    #1; check_comb1("seq1_b", 1'b1);
    #9; a1 = 1'b1; b1 = 1'b0; SEL = 1'b0;
    #1; check_comb1("seq1_c", 1'b1);
    check("seq1_mm", {63'd0, mm1}, 64'd0);

    // Table-driven 8-bit vectors: comb mid-cycle, register after the edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      a8 = vecs[i].a; b8 = vecs[i].b; SEL = vecs[i].sel; EN = vecs[i].en;
      #1;
      check_comb8($sformatf("vec%0d", i), vecs[i].exp_comb);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_q", i), {56'd0, q8}, {56'd0, vecs[i].exp_q});
      check($sformatf("vec%0d_mm", i), {63'd0, mm8}, 64'd0);
    end

    // SEL changes just after an edge: that edge captured the old selection.
    @(negedge CLK);
    a8 = 8'hA5; b8 = 8'h3C; SEL = 1'b0; EN = 1'b1;
    @(posedge CLK);
    #1;
    SEL = 1'b1; EN = 1'b0;
    check("sel_edge_q_old", {56'd0, q8}, 64'hA5);
    @(posedge CLK);
    #1;
    check("sel_edge_q_hold", {56'd0, q8}, 64'hA5);
    EN = 1'b1;
    @(posedge CLK);
    #1;
    check("sel_edge_q_new", {56'd0, q8}, 64'h3C);

    // Exhaustive WIDTH=1 sweep.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      @(negedge CLK);
      a1 = v[2]; b1 = v[1]; SEL = v[0]; EN = 1'b1;
      exp1 = v[0] ? v[1] : v[2];
      #1;
      check_comb1($sformatf("sweep%0d", i), exp1);
      @(posedge CLK);
      #1;
      check($sformatf("sweep%0d_q", i), {63'd0, q1}, {63'd0, exp1});
      check($sformatf("sweep%0d_mm", i), {63'd0, mm1}, 64'd0);
    end

    // Corrupt gate-path bit 0 for one edge; flag is sticky, reset clears it.
    @(negedge CLK);
    a8 = 8'hA5; b8 = 8'h3C; SEL = 1'b0; EN = 1'b1;
    #1;
    check("pre_force_mm", {63'd0, mm8}, 64'd0);
    force u_dut8.gates_s = 8'hA4;
    @(posedge CLK);
    #1;
    release u_dut8.gates_s;
    #1;
    check("released_gates", {56'd0, g8}, 64'hA5);
    @(negedge CLK);
    check("force_mm_set", {63'd0, mm8}, {63'd0, XCHK});
    @(posedge CLK);
    #1;
    check("force_mm_sticky", {63'd0, mm8}, {63'd0, XCHK});
    check("force_q", {56'd0, q8}, 64'hA5);
    check("force_mm1_clean", {63'd0, mm1}, 64'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_mm", {63'd0, mm8}, 64'd0);
    check("async_rst_q", {56'd0, q8}, 64'd0);
    check_comb8("async_rst_comb", 8'hA5);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_q", {56'd0, q8}, 64'hA5);
    check("post_rst_mm", {63'd0, mm8}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux2_1.md
# mux2_1

Width-parameterised 2:1 multiplexer built in three independent coding styles: gate-level primitives, dataflow continuous assignment and behavioural procedural block. All three are elaborated side by side with a registered output stage and an optional cross-check comparator. The block serves as the reference selector cell in the datapath library, and the cross-check provides a self-test of equivalence between the three implementations.

## Interface
Parameters:
- WIDTH, 1, bit width of A, B and all data outputs (legal 1..64)

Ports:
- CLK  input  1  rising-edge clock for the output register and the checker
- RST_N  input  1  asynchronous active-low reset
- A  input  WIDTH  data input, selected when SEL=0
- B  input  WIDTH  data input, selected when SEL=1
- SEL  input  1  select
- EN  input  1  register load enable
- OUT_GATES  output  WIDTH  combinational result, gate-level style
- OUT_DATAFLOW  output  WIDTH  combinational result, dataflow style
- OUT_BEHAVIORAL  output  WIDTH  combinational result, behavioural style
- OUT_Q  output  WIDTH  registered result, taken from the behavioural path
- MISMATCH  output  1  sticky flag: the three combinational results disagreed

## Operation
- Function, per bit i: OUT[i] = SEL ? B[i] : A[i].
- Gate style: per-bit generate loop of `not`, `and` and `or` primitives, implementing (A & ~SEL) | (B & SEL). No operators and no procedural code.
- Dataflow style: a single `assign` statement using `?:`.
- Behavioural style: `always @*` block with if/else on SEL, fully assigned on every path, so no latch is inferred.
- The three paths share no logic. Each is driven directly from A, B and SEL.
- OUT_Q loads OUT_BEHAVIORAL on a rising CLK edge when EN=1 and holds when EN=0.
- Checker: on every rising CLK edge with RST_N high, MISMATCH is set to 1 if any bit of OUT_GATES, OUT_DATAFLOW or OUT_BEHAVIORAL differs from the others. Once set, it stays at 1 until reset. The compare uses `!==`, so X/Z differences also count as a mismatch.
- SEL=X/Z: the behaviour of the combinational outputs is undefined. The checker may flag it, which is acceptable.

## Timing
- OUT_GATES, OUT_DATAFLOW and OUT_BEHAVIORAL are purely combinational, with zero cycles of latency.
- OUT_Q has one cycle of latency. A value applied before edge n appears after edge n, provided EN=1.
- MISMATCH rises after the first edge at which the disagreement is sampled.
- Reset is asynchronous. While RST_N=0, OUT_Q=0 and MISMATCH=0 immediately, independent of CLK.
- Release of RST_N is sampled synchronously. The first load can occur on the first rising edge after RST_N goes high.
- Reset asserted mid-operation clears OUT_Q and MISMATCH at once. The combinational outputs are unaffected by reset.
- EN and SEL changing on the same edge: the register captures the value selected by SEL before that edge.

## Configuration
- MUX2_1_CROSSCHECK_EN defined: the checker is compiled in and MISMATCH behaves as described above.
- MUX2_1_CROSSCHECK_EN undefined: no compare logic and no checker flop are built. MISMATCH is tied to constant 0. All other behaviour is identical.

## Test plan
- Reset, then A=0, B=0, SEL=0 -> all three combinational outputs 0, OUT_Q=0, MISMATCH=0.
- A=1, B=1, SEL=0, then A=0, SEL=1, then A=1, B=0, SEL=0 (10 ns apart) -> combinational outputs 1, 1, 1, all three styles equal, MISMATCH stays 0.
- WIDTH=8, A=8'hA5, B=8'h3C, SEL toggled with EN=1 -> OUT_Q follows 8'hA5 / 8'h3C one cycle after each change. With EN=0, OUT_Q holds its last value.
- Exhaustive sweep of A, B and SEL for WIDTH=1 (8 combinations) -> each output equals SEL?B:A, and MISMATCH=0 with the macro defined.
- Force OUT_GATES bit 0 to the wrong value for one cycle (macro defined) -> MISMATCH=1 from the next edge and stays set after the force is released. Asserting RST_N=0 mid-cycle clears it immediately.
- Same force with the macro undefined -> MISMATCH remains 0.
